// File: rtl/display_pkg.sv
// Shared definitions for the output display unit: FSM states, segment patterns
// and the converter's fixed dimensions.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int BCD_DIGITS   = 10;
    localparam int SHIFT_CYCLES = 32;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // |value| as unsigned; -2^31 maps naturally to 32'h8000_0000
    function automatic logic [31:0] abs_mag(input logic [31:0] value);
        return value[31] ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One seven-segment digit: BCD nibble plus blank/dash overrides, with
// selectable output polarity. Dash wins over blank.
module seg7_decoder
    import display_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    logic [6:0] pattern;

    always_comb begin
        pattern = seg_pattern(digit);
        if (dash) begin
            pattern = SEG_DASH;
        end else if (blank) begin
            pattern = SEG_BLANK;
        end
    end

    assign seg = (ACTIVE_LOW != 0) ? ~pattern : pattern;

endmodule

// File: rtl/output_display_unit.sv
// Captures OUT on each rising edge of flagOUT, converts it to sign + BCD by
// sequential double-dabble and drives DIGITS seven-segment displays.
module output_display_unit
    import display_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flagOUT,
    input  logic [31:0]           OUT,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  negative,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    state_t                      state_reg;
    logic                        flag_q_reg;
    logic                        sign_reg;
    logic [31:0]                 mag_reg;
    logic [4*BCD_DIGITS-1:0]     bcd_reg;
    logic [4:0]                  cnt_reg;
    logic                        pend_valid_reg;
    logic [31:0]                 pend_value_reg;
    logic [7*DIGITS-1:0]         hex_reg;
    logic                        negative_reg;
    logic                        overflow_reg;
    logic                        busy_reg;
    logic                        done_reg;

    logic                        trigger;
    logic [31:0]                 start_value;
    logic [4*BCD_DIGITS-1:0]     bcd_adj;
    logic                        ovf;
    logic [DIGITS-1:0]           blank;
    logic [7*DIGITS-1:0]         hex_dec;

    assign trigger     = flagOUT & ~flag_q_reg;
    // A trigger landing in the commit cycle supersedes any older pending value
    assign start_value = trigger ? OUT : pend_value_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end

        if (DIGITS < BCD_DIGITS) begin : g_ovf
            assign ovf = |bcd_reg[4*BCD_DIGITS-1:4*DIGITS];
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end

        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = (BLANK_LZ != 0) && (bcd_reg[4*BCD_DIGITS-1:4*gi] == '0);
            end
            seg7_decoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
                .digit (bcd_reg[4*gi +: 4]),
                .blank (blank[gi]),
                .dash  (ovf),
                .seg   (hex_dec[7*gi +: 7])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            flag_q_reg     <= 1'b1;
            sign_reg       <= 1'b0;
            mag_reg        <= '0;
            bcd_reg        <= '0;
            cnt_reg        <= '0;
            pend_valid_reg <= 1'b0;
            pend_value_reg <= '0;
            hex_reg        <= (ACTIVE_LOW != 0) ? '1 : '0;
            negative_reg   <= 1'b0;
            overflow_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            flag_q_reg <= flagOUT;
            done_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        sign_reg  <= OUT[31];
                        mag_reg   <= abs_mag(OUT);
                        bcd_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (trigger) begin
                        pend_valid_reg <= 1'b1;
                        pend_value_reg <= OUT;
                    end
                    {bcd_reg, mag_reg} <= {bcd_adj, mag_reg} << 1;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'(SHIFT_CYCLES - 1)) begin
                        state_reg <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    hex_reg        <= hex_dec;
                    negative_reg   <= sign_reg;
                    overflow_reg   <= ovf;
                    done_reg       <= 1'b1;
                    pend_valid_reg <= 1'b0;
                    if (trigger || pend_valid_reg) begin
                        sign_reg  <= start_value[31];
                        mag_reg   <= abs_mag(start_value);
                        bcd_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_SHIFT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign HEX      = hex_reg;
    assign negative = negative_reg;
    assign overflow = overflow_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_output_display_unit.sv
// Bench for output_display_unit: directed scenarios plus randomized OUT pulses,
// checked every cycle against a timing-level behavioural model.
module tb_output_display_unit;

    localparam int DIGITS = 8;
    localparam int W      = 7 * DIGITS;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          flagOUT = 1'b1;
    logic [31:0]   OUT     = '0;
    logic [W-1:0]  HEX;
    logic          negative;
    logic          overflow;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    output_display_unit #(.DIGITS(DIGITS), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .flagOUT  (flagOUT),
        .OUT      (OUT),
        .HEX      (HEX),
        .negative (negative),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint model_abs(input logic [31:0] v);
        longint m;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        return m;
    endfunction

    function automatic logic model_ovf(input logic [31:0] v);
        longint lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        return model_abs(v) >= lim;
    endfunction

    // Decimal digits by repeated division, leading zeros blanked, active-low output
    function automatic logic [W-1:0] model_hex(input logic [31:0] v);
        longint     m;
        int         d [DIGITS];
        int         msd;
        logic [6:0] p;
        logic [W-1:0] h;
        m   = model_abs(v);
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = int'(m % 10);
            m    = m / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (model_ovf(v))  p = 7'h40;
            else if (i > msd)  p = 7'h00;
            else               p = seg_tab[d[i]];
            h[7*i +: 7] = ~p;
        end
        return h;
    endfunction

    // Behavioural model: conversion windows of 33 edges, one-deep last-wins pending slot
    logic         m_valid = 1'b0;
    logic         m_prev  = 1'b1;
    logic         m_active = 1'b0;
    logic         m_pend  = 1'b0;
    logic         m_trig;
    logic [31:0]  m_cur   = '0;
    logic [31:0]  m_pendv = '0;
    longint       m_commit_at = 0;
    longint       cyc = 0;
    logic [W-1:0] m_hex = '1;
    logic         m_neg = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_done = 1'b0;

    always @(posedge clock) begin
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            m_valid  = 1'b1;
            m_prev   = 1'b1;
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_hex    = '1;
            m_neg    = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_trig = flagOUT && !m_prev;
            m_prev = flagOUT;
            if (m_active && cyc == m_commit_at) begin
                m_hex  = model_hex(m_cur);
                m_neg  = m_cur[31];
                m_ovf  = model_ovf(m_cur);
                m_done = 1'b1;
                if (m_trig) begin
                    m_cur = OUT; m_commit_at = cyc + 33; m_pend = 1'b0;
                end else if (m_pend) begin
                    m_cur = m_pendv; m_commit_at = cyc + 33; m_pend = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_trig) begin
                if (m_active) begin
                    m_pend = 1'b1; m_pendv = OUT;
                end else begin
                    m_active = 1'b1; m_cur = OUT; m_commit_at = cyc + 33;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("hex", 64'(HEX), 64'(m_hex));
            chk("negative", 64'(negative), 64'(m_neg));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(m_done));
        end
    end

    task automatic pulse(input logic [31:0] v, input int len);
        OUT = v;
        flagOUT = 1'b1;
        @(negedge clock);
        for (int j = 1; j < len; j++) begin
            OUT = $urandom;
            @(negedge clock);
        end
        flagOUT = 1'b0;
        OUT = $urandom;
        @(negedge clock);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 80) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_done_seen"}, 64'(done), 64'd1);
    endtask

    initial begin
        int busy_cnt, falls, done_cnt;
        logic prev_busy;
        logic [31:0] v;
        int sel;

        // Scenario 1: flagOUT held high through reset release
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("t1_hex_off", 64'(HEX), 64'(56'hFF_FFFF_FFFF_FFFF));
        chk("t1_busy", 64'(busy), 64'd0);
        flagOUT = 1'b0;
        repeat (3) @(negedge clock);

        // Scenario 2: 1234
        pulse(32'd1234, 1);
        chk("t2_busy_next", 64'(busy), 64'd1);
        wait_done("t2");
        chk("t2_d0", 64'(HEX[6:0]), 64'h19);
        chk("t2_d1", 64'(HEX[13:7]), 64'h30);
        chk("t2_d2", 64'(HEX[20:14]), 64'h24);
        chk("t2_d3", 64'(HEX[27:21]), 64'h79);
        chk("t2_upper_blank", 64'(HEX[55:28]), 64'hFFF_FFFF);
        @(negedge clock);
        chk("t2_done_single", 64'(done), 64'd0);

        // Scenario 3: -7 and 0
        pulse(32'hFFFF_FFF9, 1);
        wait_done("t3a");
        chk("t3_m7_d0", 64'(HEX[6:0]), 64'h78);
        chk("t3_m7_neg", 64'(negative), 64'd1);
        pulse(32'd0, 1);
        wait_done("t3b");
        chk("t3_zero_hex", 64'(HEX), 64'(56'hFF_FFFF_FFFF_FFC0));
        chk("t3_zero_neg", 64'(negative), 64'd0);

        // Scenario 4: range boundary
        pulse(32'd99999999, 2);
        wait_done("t4a");
        chk("t4_nines", 64'(HEX), 64'(56'h20_4081_0204_0810));
        chk("t4_nines_ovf", 64'(overflow), 64'd0);
        pulse(32'd100000000, 1);
        wait_done("t4b");
        chk("t4_dash", 64'(HEX), 64'(56'h7E_FDFB_F7EF_DFBF));
        chk("t4_dash_ovf", 64'(overflow), 64'd1);
        pulse(32'h8000_0000, 1);
        wait_done("t4c");
        chk("t4_min_dash", 64'(HEX), 64'(56'h7E_FDFB_F7EF_DFBF));
        chk("t4_min_ovf", 64'(overflow), 64'd1);
        chk("t4_min_neg", 64'(negative), 64'd1);

        // Scenario 5: 5, then 6 and 9 while busy; 6 is dropped
        busy_cnt = 0; falls = 0; done_cnt = 0; prev_busy = 1'b0;
        for (int i = 0; i < 110; i++) begin
            if (i == 0)  begin flagOUT = 1'b1; OUT = 32'd5; end
            if (i == 1)  flagOUT = 1'b0;
            if (i == 5)  begin flagOUT = 1'b1; OUT = 32'd6; end
            if (i == 6)  flagOUT = 1'b0;
            if (i == 12) begin flagOUT = 1'b1; OUT = 32'd9; end
            if (i == 14) flagOUT = 1'b0;
            @(negedge clock);
            if (busy) busy_cnt++;
            if (prev_busy && !busy) falls++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) chk("t5_first_is_5", 64'(HEX[6:0]), 64'h12);
            end
            prev_busy = busy;
        end
        chk("t5_done_count", 64'(done_cnt), 64'd2);
        chk("t5_busy_cycles", 64'(busy_cnt), 64'd66);
        chk("t5_busy_falls", 64'(falls), 64'd1);
        chk("t5_last_is_9", 64'(HEX[6:0]), 64'h10);

        // Scenario 6: reset during SHIFT aborts the conversion
        pulse(32'd77, 1);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        chk("t6_hex_off", 64'(HEX), 64'(56'hFF_FFFF_FFFF_FFFF));
        pulse(32'd77, 1);
        wait_done("t6");
        chk("t6_d0", 64'(HEX[6:0]), 64'h78);
        chk("t6_d1", 64'(HEX[13:7]), 64'h78);

        // Randomized pulses, gaps short enough to hit busy and commit-cycle triggers
        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: v = $urandom_range(0, 999);
                1: v = -$urandom_range(0, 999);
                2: v = $urandom;
                3: begin
                    v = 32'd99999990 + $urandom_range(0, 20);
                    if ($urandom_range(0, 1) == 1) v = -v;
                end
                4: case ($urandom_range(0, 3))
                       0: v = 32'h0000_0000;
                       1: v = 32'h8000_0000;
                       2: v = 32'h7FFF_FFFF;
                       default: v = 32'hFFFF_FFFF;
                   endcase
                default: v = $urandom_range(0, 100000000);
            endcase
            pulse(v, int'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 45)) @(negedge clock);
        end
        repeat (80) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
